video_timing: RTL and testbench
===============================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter H_VISIBLE, 1024, active pixels per line.
REQ-002 Parameter H_FP, 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 136, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 160, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 768, active lines per frame.
REQ-006 Parameter V_FP, 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 6, vertical sync width in lines.
REQ-008 Parameter V_BP, 29, vertical back porch in lines.
REQ-009 Parameter HS_POL, 0, hsync active level (0 = active-low).
REQ-010 Parameter VS_POL, 0, vsync active level (0 = active-low).
REQ-011 clk_pixel  input  1  pixel clock; one clock domain, all logic on its rising edge.
REQ-012 reset  input  1  synchronous, active-high reset.
REQ-013 en  input  1  advance enable; counters step only when 1.
REQ-014 hcnt  output  11  horizontal pixel position; 0..H_VISIBLE-1 is visible.
REQ-015 vcnt  output  11  vertical line position; 0..V_VISIBLE-1 is visible.
REQ-016 hsync  output  1  horizontal sync at HS_POL level when active.
REQ-017 vsync  output  1  vertical sync at VS_POL level when active.
REQ-018 de  output  1  data enable, high in the visible region.
REQ-019 line_start  output  1  one-cycle pulse when hcnt wraps to 0.
REQ-020 frame_start  output  1  one-cycle pulse when (hcnt,vcnt) wraps to (0,0).
REQ-021 frame_cnt  output  8  frame counter, modulo 256.

Function
REQ-022 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP shall each be at most 2048; defaults give 1344 and 806.
REQ-023 All outputs shall be registered, with no combinational path from en to any output.
REQ-024 When en=1, hcnt shall increment by 1; at H_TOTAL-1 it shall wrap to 0 and vcnt shall increment.
REQ-025 When hcnt wraps and vcnt=V_TOTAL-1, vcnt shall wrap to 0 and frame_cnt shall increment, wrapping from 255 to 0.
REQ-026 Alignment: hsync, vsync, de, line_start and frame_start in any cycle shall describe the hcnt/vcnt values output in that same cycle, decoded from the next-count values.
REQ-027 de shall be 1 exactly when hcnt<H_VISIBLE and vcnt<V_VISIBLE.
REQ-028 hsync shall be active exactly when H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC; defaults give hcnt 1048..1183.
REQ-029 vsync shall be active exactly when V_VISIBLE+V_FP <= vcnt < V_VISIBLE+V_FP+V_SYNC, for every hcnt of those lines; defaults give vcnt 771..776.
REQ-030 line_start shall be 1 only in the cycle following an en=1 step that wrapped hcnt to 0.
REQ-031 frame_start shall be 1 only in the cycle following an en=1 step that wrapped both counters to 0; line_start is also 1 in that cycle.
REQ-032 When en=0, hcnt, vcnt, hsync, vsync, de and frame_cnt shall hold, and line_start and frame_start shall be 0.
REQ-033 Pulses shall never last longer than one cycle, even if en is held at 1 at a wrap.

Reset
REQ-034 reset=1 at a clock edge shall take priority over en and shall set hcnt=0, vcnt=0, frame_cnt=0, de=1, hsync=~HS_POL, vsync=~VS_POL, line_start=0 and frame_start=0.
REQ-035 Reset asserted mid-frame shall discard the current position, with no pulse on reset or on its release.
REQ-036 In the first en=1 cycle after reset, hcnt shall go from 0 to 1.

Verification
REQ-037 Reset check: assert reset, then release with en=1 -> hcnt=0, vcnt=0, de=1, hsync=1, vsync=1, frame_cnt=0; next cycle hcnt=1.
REQ-038 One line (defaults): de high 1024 cycles, hsync low 136 cycles starting at hcnt=1048, hcnt goes 1343->0, vcnt goes 0->1, line_start pulses once.
REQ-039 One frame: frame_start pulses every 1083264 cycles, vsync low 8064 cycles starting at (0,771), and frame_cnt increments by 1 per frame.
REQ-040 Stall at hcnt=1343, vcnt=805 with en=0 for 10 cycles -> all outputs held, no pulses; en=1 -> (0,0) with frame_start=1 and line_start=1.
REQ-041 Reset at hcnt=500, vcnt=400 -> next cycle shows reset values from REQ-034, with no frame_start.
REQ-042 Small configuration (H 8/1/2/1, V 4/1/1/1, HS_POL=1): run 256 frames -> frame_cnt goes 255->0, and hsync is high exactly at hcnt 9..10.

Source files
------------

// File: rtl/video_timing_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_if
// Description : Advance enable plus raster position, sync and pulse outputs
//               of the video timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_if;
    logic        en;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        input  en,
        output hcnt,
        output vcnt,
        output hsync,
        output vsync,
        output de,
        output line_start,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        output en,
        input  hcnt,
        input  vcnt,
        input  hsync,
        input  vsync,
        input  de,
        input  line_start,
        input  frame_start,
        input  frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
// Module      : video_timing
// Description : Raster timing generator: pixel/line counters, sync, data
//               enable, line/frame start pulses and a frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0
) (
    input  logic             clk_pixel,
    input  logic             reset,
    video_timing_if.master   vt
);

    localparam int          c_H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] c_H_LAST    = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST    = 11'(c_V_TOTAL - 1);
    // Decode thresholds are 12 bits wide so a region ending at 2048 still fits.
    localparam logic [11:0] c_H_VIS     = 12'(H_VISIBLE);
    localparam logic [11:0] c_V_VIS     = 12'(V_VISIBLE);
    localparam logic [11:0] c_HS_START  = 12'(H_VISIBLE + H_FP);
    localparam logic [11:0] c_HS_END    = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [11:0] c_VS_START  = 12'(V_VISIBLE + V_FP);
    localparam logic [11:0] c_VS_END    = 12'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic        c_HS_ACTIVE = (HS_POL != 0);
    localparam logic        c_VS_ACTIVE = (VS_POL != 0);

    logic [10:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic [7:0]  r_frame_cnt;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic        r_line_start;
    logic        r_frame_start;

    logic [10:0] w_hcnt_nxt;
    logic [10:0] w_vcnt_nxt;
    logic [7:0]  w_frame_cnt_nxt;
    logic        w_hsync_nxt;
    logic        w_vsync_nxt;
    logic        w_de_nxt;
    logic        w_line_start_nxt;
    logic        w_frame_start_nxt;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [11:0] w_h_ext;
    logic [11:0] w_v_ext;

    always_comb begin
        w_h_wrap        = (r_hcnt == c_H_LAST);
        w_v_wrap        = (r_vcnt == c_V_LAST);
        w_hcnt_nxt      = r_hcnt;
        w_vcnt_nxt      = r_vcnt;
        w_frame_cnt_nxt = r_frame_cnt;

        if (vt.en) begin
            if (w_h_wrap) begin
                w_hcnt_nxt = 11'd0;
                if (w_v_wrap) begin
                    w_vcnt_nxt      = 11'd0;
                    w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                end else begin
                    w_vcnt_nxt = r_vcnt + 11'd1;
                end
            end else begin
                w_hcnt_nxt = r_hcnt + 11'd1;
            end
        end

        // Pulses are re-evaluated every cycle, so they can never stretch.
        w_line_start_nxt  = vt.en & w_h_wrap;
        w_frame_start_nxt = vt.en & w_h_wrap & w_v_wrap;

        // Decode from the next count so each output lines up with its position.
        w_h_ext     = {1'b0, w_hcnt_nxt};
        w_v_ext     = {1'b0, w_vcnt_nxt};
        w_de_nxt    = (w_h_ext < c_H_VIS) && (w_v_ext < c_V_VIS);
        w_hsync_nxt = ((w_h_ext >= c_HS_START) && (w_h_ext < c_HS_END)) ?
                      c_HS_ACTIVE : ~c_HS_ACTIVE;
        w_vsync_nxt = ((w_v_ext >= c_VS_START) && (w_v_ext < c_VS_END)) ?
                      c_VS_ACTIVE : ~c_VS_ACTIVE;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_hcnt        <= 11'd0;
            r_vcnt        <= 11'd0;
            r_frame_cnt   <= 8'd0;
            r_de          <= 1'b1;
            r_hsync       <= ~c_HS_ACTIVE;
            r_vsync       <= ~c_VS_ACTIVE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcnt        <= w_hcnt_nxt;
            r_vcnt        <= w_vcnt_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_de          <= w_de_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_line_start  <= w_line_start_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign vt.hcnt        = r_hcnt;
    assign vt.vcnt        = r_vcnt;
    assign vt.frame_cnt   = r_frame_cnt;
    assign vt.de          = r_de;
    assign vt.hsync       = r_hsync;
    assign vt.vsync       = r_vsync;
    assign vt.line_start  = r_line_start;
    assign vt.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing
// Description : Self-checking bench for video_timing, default and small
//               raster, against a linear pixel-index reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing;

    logic clk = 1'b0;
    logic rst;
    logic en_drv;

    always #5 clk = ~clk;

    video_timing_if vif_d ();
    video_timing_if vif_s ();
    assign vif_d.en = en_drv;
    assign vif_s.en = en_drv;

    video_timing u_dut_d (
        .clk_pixel (clk),
        .reset     (rst),
        .vt        (vif_d)
    );

    video_timing #(
        .H_VISIBLE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL    (1), .VS_POL (0)
    ) u_dut_s (
        .clk_pixel (clk),
        .reset     (rst),
        .vt        (vif_s)
    );

    // Index 0 = default raster, index 1 = small raster
    int hv  [2] = '{1024, 8};
    int hfp [2] = '{24, 1};
    int hsw [2] = '{136, 2};
    int hbp [2] = '{160, 1};
    int vv  [2] = '{768, 4};
    int vfp [2] = '{3, 1};
    int vsw [2] = '{6, 1};
    int vbp [2] = '{29, 1};
    int hpol[2] = '{0, 1};
    int vpol[2] = '{0, 0};

    int pos [2];
    int fc  [2];
    bit mls [2];
    bit mfs [2];

    int checks = 0;
    int errors = 0;

    function automatic int htot(input int id);
        return hv[id] + hfp[id] + hsw[id] + hbp[id];
    endfunction

    function automatic int vtot(input int id);
        return vv[id] + vfp[id] + vsw[id] + vbp[id];
    endfunction

    // {hcnt, vcnt, hsync, vsync, de, line_start, frame_start, frame_cnt}
    function automatic logic [34:0] expv(input int id);
        int   ht, h, v;
        logic hs_on, vs_on, de_on, hsv, vsv;
        ht    = htot(id);
        h     = pos[id] % ht;
        v     = pos[id] / ht;
        hs_on = (h >= hv[id] + hfp[id]) && (h < hv[id] + hfp[id] + hsw[id]);
        vs_on = (v >= vv[id] + vfp[id]) && (v < vv[id] + vfp[id] + vsw[id]);
        de_on = (h < hv[id]) && (v < vv[id]);
        hsv   = hs_on ? (hpol[id] != 0) : (hpol[id] == 0);
        vsv   = vs_on ? (vpol[id] != 0) : (vpol[id] == 0);
        return {11'(h), 11'(v), hsv, vsv, de_on, mls[id], mfs[id], 8'(fc[id])};
    endfunction

    function automatic logic [34:0] act(input int id);
        if (id == 0)
            return {vif_d.hcnt, vif_d.vcnt, vif_d.hsync, vif_d.vsync, vif_d.de,
                    vif_d.line_start, vif_d.frame_start, vif_d.frame_cnt};
        return {vif_s.hcnt, vif_s.vcnt, vif_s.hsync, vif_s.vsync, vif_s.de,
                vif_s.line_start, vif_s.frame_start, vif_s.frame_cnt};
    endfunction

    // Apply inputs, take one clock edge, advance the model, settle past the edge.
    task automatic tick(input logic e, input logic r);
        en_drv = e;
        rst    = r;
        @(posedge clk);
        for (int id = 0; id < 2; id++) begin
            if (r) begin
                pos[id] = 0; fc[id] = 0; mls[id] = 1'b0; mfs[id] = 1'b0;
            end else if (e) begin
                pos[id] = (pos[id] + 1) % (htot(id) * vtot(id));
                mls[id] = (pos[id] % htot(id)) == 0;
                mfs[id] = (pos[id] == 0);
                if (mfs[id]) fc[id] = (fc[id] + 1) % 256;
            end else begin
                mls[id] = 1'b0; mfs[id] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int id = 0; id < 2; id++) begin
            checks++;
            if (act(id) !== expv(id)) begin
                errors++;
                $display("FAIL reset_state dut=%0d got=%h exp=%h", id, act(id), expv(id));
            end
        end
        checks++;
        if (act(0) !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", act(0),
                     {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        checks++;
        if (vif_s.hsync !== 1'b0 || vif_s.vsync !== 1'b1) begin
            errors++;
            $display("FAIL reset_pol_small got hs=%b vs=%b exp hs=0 vs=1", vif_s.hsync, vif_s.vsync);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (vif_d.hcnt !== 11'd1 || vif_d.line_start !== 1'b0) begin
            errors++;
            $display("FAIL first_step got hcnt=%0d ls=%b exp hcnt=1 ls=0", vif_d.hcnt, vif_d.line_start);
        end
    endtask

    task automatic test_random;
        logic e, r;
        for (int i = 0; i < 4000; i++) begin
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 999) == 0);
            tick(e, r);
            for (int id = 0; id < 2; id++) begin
                checks++;
                if (act(id) !== expv(id)) begin
                    errors++;
                    $display("FAIL random dut=%0d step=%0d got=%h exp=%h", id, i, act(id), expv(id));
                end
            end
        end
    endtask

    task automatic test_line;
        int de_n = 0, hs_n = 0, hs_first = -1, ls_n = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 1344; i++) begin
            if (vif_d.de === 1'b1) de_n++;
            if (vif_d.hsync === 1'b0) begin
                if (hs_first < 0) hs_first = int'(vif_d.hcnt);
                hs_n++;
            end
            if (vif_d.line_start === 1'b1) ls_n++;
            tick(1'b1, 1'b0);
            checks++;
            if (act(0) !== expv(0)) begin
                errors++;
                $display("FAIL line_model step=%0d got=%h exp=%h", i, act(0), expv(0));
            end
        end
        if (vif_d.line_start === 1'b1) ls_n++;
        checks++;
        if (de_n != 1024) begin
            errors++; $display("FAIL line_de_count got=%0d exp=1024", de_n);
        end
        checks++;
        if (hs_n != 136 || hs_first != 1048) begin
            errors++; $display("FAIL line_hsync got n=%0d start=%0d exp n=136 start=1048", hs_n, hs_first);
        end
        checks++;
        if (ls_n != 1 || vif_d.hcnt !== 11'd0 || vif_d.vcnt !== 11'd1 || vif_d.line_start !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap got ls_n=%0d h=%0d v=%0d exp ls_n=1 h=0 v=1", ls_n, vif_d.hcnt, vif_d.vcnt);
        end
    endtask

    task automatic test_frame;
        int last = 0, fs_n = 0, vs_n = 0, vs_h = -1, vs_v = -1;
        tick(1'b0, 1'b1);
        for (int n = 1; n <= 252; n++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (act(1) !== expv(1)) begin
                errors++;
                $display("FAIL frame_model step=%0d got=%h exp=%h", n, act(1), expv(1));
            end
            if (vif_s.frame_start === 1'b1) begin
                checks++;
                if (n - last != 84) begin
                    errors++; $display("FAIL frame_period got=%0d exp=84", n - last);
                end
                last = n;
                fs_n++;
            end
            if (vif_s.vsync === 1'b0) begin
                if (vs_h < 0) begin vs_h = int'(vif_s.hcnt); vs_v = int'(vif_s.vcnt); end
                vs_n++;
            end
        end
        checks++;
        if (fs_n != 3 || vif_s.frame_cnt !== 8'd3) begin
            errors++; $display("FAIL frame_count got fs=%0d fc=%0d exp fs=3 fc=3", fs_n, vif_s.frame_cnt);
        end
        checks++;
        if (vs_n != 36 || vs_h != 0 || vs_v != 5) begin
            errors++;
            $display("FAIL frame_vsync got n=%0d at (%0d,%0d) exp n=36 at (0,5)", vs_n, vs_h, vs_v);
        end
    endtask

    task automatic test_stall;
        tick(1'b0, 1'b1);
        repeat (83) tick(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (act(1) !== {11'd11, 11'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, act(1),
                         {11'd11, 11'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
            end
        end
        tick(1'b1, 1'b0);
        checks++;
        if (act(1) !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL stall_release got=%h exp=%h", act(1),
                     {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1});
        end
        tick(1'b1, 1'b0);
        checks++;
        if (vif_s.line_start !== 1'b0 || vif_s.frame_start !== 1'b0 || vif_s.hcnt !== 11'd1) begin
            errors++;
            $display("FAIL pulse_width got ls=%b fs=%b h=%0d exp ls=0 fs=0 h=1",
                     vif_s.line_start, vif_s.frame_start, vif_s.hcnt);
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b0, 1'b1);
        repeat (500) tick(1'b1, 1'b0);
        checks++;
        if (vif_d.hcnt !== 11'd500) begin
            errors++; $display("FAIL mid_setup got hcnt=%0d exp=500", vif_d.hcnt);
        end
        tick(1'b1, 1'b1);
        for (int id = 0; id < 2; id++) begin
            checks++;
            if (act(id) !== expv(id)) begin
                errors++;
                $display("FAIL mid_reset dut=%0d got=%h exp=%h", id, act(id), expv(id));
            end
        end
        tick(1'b0, 1'b0);
        checks++;
        if (act(0) !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_release got=%h exp=%h", act(0),
                     {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        tick(1'b1, 1'b0);
        checks++;
        if (act(0) !== {11'd1, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_first_step got=%h exp=%h", act(0),
                     {11'd1, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_wrap256;
        logic [11:0] hs_mask = '0;
        bit saw255 = 1'b0, wrapped = 1'b0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 256 * 84; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (act(1) !== expv(1)) begin
                errors++;
                $display("FAIL wrap_model step=%0d got=%h exp=%h", i, act(1), expv(1));
            end
            if (vif_s.hsync === 1'b1 && vif_s.hcnt < 11'd12) hs_mask[vif_s.hcnt[3:0]] = 1'b1;
            if (vif_s.frame_cnt === 8'd255) saw255 = 1'b1;
            if (saw255 && vif_s.frame_start === 1'b1 && vif_s.frame_cnt === 8'd0) wrapped = 1'b1;
        end
        checks++;
        if (!saw255 || !wrapped || vif_s.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap got saw255=%b wrapped=%b fc=%0d exp 1 1 0",
                     saw255, wrapped, vif_s.frame_cnt);
        end
        checks++;
        if (hs_mask !== 12'h600) begin
            errors++; $display("FAIL small_hsync_cols got=%h exp=600", hs_mask);
        end
    endtask

    initial begin
        en_drv = 1'b0;
        rst    = 1'b1;
        test_reset;
        test_random;
        test_line;
        test_frame;
        test_stall;
        test_reset_mid;
        test_wrap256;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
